icache_ctrl: RTL and testbench

Direct-mapped, read-only instruction cache between the PC register and the slow instruction memory. It is the responder for the fetch address the PC drives each cycle. On a hit it returns the instruction in the same cycle. On a miss it raises `stall_o`, which feeds the PC stall-hold input and the IF/ID hold logic, then fetches a full line over a req/ack handshake and resumes.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_if.sv | 10 +
 rtl/icache_line_array.sv | 46 ++++
 rtl/icache_ctrl.sv | 102 ++++++++++
 tb/tb_icache_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;
  typedef enum logic {IDLE, FILL} state_e;

  localparam int DEF_LINES = 32;
  localparam int DEF_WORDS = 8;
  localparam int OFF_W     = $clog2(DEF_WORDS);
  localparam int IDX_W     = $clog2(DEF_LINES);
  localparam int TAG_W     = 32 - IDX_W - OFF_W - 2;

  localparam logic [31:0] NOP = 32'h0;

  // Clears the byte and word offset so the address points at the start of a line.
  function automatic logic [31:0] line_align(input logic [31:0] a, input int off_w);
    return a & ~((32'd4 << off_w) - 32'd1);
  endfunction
endpackage

// File: rtl/icache_if.sv
// Line-fill bus between the cache (master) and instruction memory (slave).
interface icache_if #(parameter int LINE_W = 256) ();
  logic              mem_req_o;
  logic [31:0]       mem_addr_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_i;

  modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_data_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_data_i);
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one write port, combinational read, flush and reset clear valids.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int WORDS  = DEF_WORDS,
  parameter int IDX_W  = $clog2(LINES),
  parameter int TAG_W  = 32 - $clog2(LINES) - $clog2(WORDS) - 2,
  parameter int LINE_W = 32 * WORDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_flush,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_data
);
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];

  // Flush outranks a coincident fill write so the filled line stays invalid.
  for (genvar l = 0; l < LINES; l++) begin : g_vld
    always_ff @(posedge clk_i) begin
      if (!rst_i)                                      r_valid[l] <= 1'b0;
      else if (i_flush)                                r_valid[l] <= 1'b0;
      else if (i_we && (i_widx == IDX_W'(l)))          r_valid[l] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx];
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only I-cache: zero-latency hits, stall plus line fill on a miss.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic        stall_o,
  icache_if.master    mem,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 32 - IDX_W - OFF_W - 2;
  localparam int LINE_W = 32 * WORDS;

  state_e                r_state, w_nstate;
  logic                  r_mem_req;
  logic [31:0]           r_mem_addr;
  logic [31:0]           r_hit_cnt, r_miss_cnt;
  logic                  w_start, w_we, w_hit;
  logic                  w_valid;
  logic [TAG_W-1:0]      w_tag;
  logic [LINE_W-1:0]     w_data;
  logic [WORDS-1:0][31:0] w_words;

  wire [OFF_W-1:0] w_off   = addr_i[OFF_W+1:2];
  wire [IDX_W-1:0] w_idx   = addr_i[OFF_W+2 +: IDX_W];
  wire [TAG_W-1:0] w_atag  = addr_i[31 -: TAG_W];

  icache_line_array #(
    .LINES(LINES), .WORDS(WORDS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)
  ) u_arr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_flush (flush_i),
    .i_we    (w_we),
    .i_widx  (r_mem_addr[OFF_W+2 +: IDX_W]),
    .i_wtag  (r_mem_addr[31 -: TAG_W]),
    .i_wdata (mem.mem_data_i),
    .i_ridx  (w_idx),
    .o_valid (w_valid),
    .o_tag   (w_tag),
    .o_data  (w_data)
  );

  assign w_words = w_data;
  assign w_hit   = req_i && w_valid && (w_tag == w_atag) && (r_state == IDLE);
  assign instr_o = w_hit ? w_words[w_off] : NOP;
  assign stall_o = req_i && !w_hit;

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_nstate;
  end

  // A miss coinciding with a flush waits a cycle so it looks up post-flush state.
  always_comb begin
    w_nstate = r_state;
    w_start  = 1'b0;
    w_we     = 1'b0;
    case (r_state)
      IDLE: if (req_i && !w_hit && !flush_i) begin
        w_nstate = FILL;
        w_start  = 1'b1;
      end
      FILL: if (mem.mem_ack_i) begin
        w_we     = 1'b1;
        w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_hit_cnt  <= 32'h0;
      r_miss_cnt <= 32'h0;
    end else begin
      r_mem_req <= (w_nstate == FILL);
      if (w_start) begin
        r_mem_addr <= line_align(addr_i, OFF_W);
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
      if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
    end
  end

  assign mem.mem_req_o  = r_mem_req;
  assign mem.mem_addr_o = r_mem_addr;
  assign hit_cnt_o      = r_hit_cnt;
  assign miss_cnt_o     = r_miss_cnt;
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: fills, hits, conflicts, flush races, reset mid-fill.
module tb_icache_ctrl;
  localparam int LW = 256;

  logic        clk = 1'b0;
  logic        rst_i, req_i, flush_i;
  logic [31:0] addr_i, instr_o, hit_cnt_o, miss_cnt_o;
  logic        stall_o;
  int          n_chk = 0, n_err = 0;
  logic [LW-1:0] line1, line2, line3;

  always #5 clk = ~clk;

  icache_if #(.LINE_W(LW)) mif ();

  icache_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .flush_i    (flush_i),
    .instr_o    (instr_o),
    .stall_o    (stall_o),
    .mem        (mif.master),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] mkline(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  // Miss at addr a, ack arrives dly cycles after the miss cycle; returns at the cycle after ack.
  task automatic fill(input logic [31:0] a, input logic [LW-1:0] line, input int dly, input bit fl);
    @(negedge clk);
    req_i = 1'b1; addr_i = a;
    #1;
    chk("miss_stall", stall_o, 1'b1);
    chk("miss_noreq", mif.mem_req_o, 1'b0);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      #1;
      chk("fill_req", mif.mem_req_o, 1'b1);
      chk("fill_addr", mif.mem_addr_o, a & ~32'h1F);
      chk("fill_stall", stall_o, 1'b1);
      if (i == dly - 1) begin
        mif.mem_ack_i = 1'b1; mif.mem_data_i = line; flush_i = fl;
      end
    end
    @(negedge clk);
    mif.mem_ack_i = 1'b0; flush_i = 1'b0;
    #1;
  endtask

  initial begin
    line1 = mkline(32'h1000_0000);
    line1[2*32 +: 32] = 32'hDEAD_BEEF;
    line2 = mkline(32'h2000_0000);
    line3 = mkline(32'h3000_0000);
    rst_i = 1'b0; req_i = 1'b0; addr_i = 32'h0; flush_i = 1'b0;
    mif.mem_ack_i = 1'b0; mif.mem_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_mreq", mif.mem_req_o, 1'b0);
    chk("rst_maddr", mif.mem_addr_o, 32'h0);
    chk("rst_hits", hit_cnt_o, 32'h0);
    chk("rst_miss", miss_cnt_o, 32'h0);
    rst_i = 1'b1;

    // First fill, ack three cycles after the miss
    fill(32'h40, line1, 3, 1'b0);
    chk("f1_stall", stall_o, 1'b0);
    chk("f1_mreq", mif.mem_req_o, 1'b0);
    chk("f1_w0", instr_o, 32'h1000_0000);
    @(negedge clk);
    addr_i = 32'h48;
    #1;
    chk("f1_w2", instr_o, 32'hDEAD_BEEF);
    chk("f1_miss", miss_cnt_o, 32'd1);

    // Sequential line walk: all hits
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      addr_i = 32'h40 + 32'(4 * k);
      #1;
      chk("seq_stall", stall_o, 1'b0);
      chk("seq_instr", instr_o, (k == 2) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(k));
    end
    @(negedge clk);
    req_i = 1'b0;
    #1;
    chk("seq_hits", hit_cnt_o, 32'd10);

    // Conflict on index 2, minimum miss penalty
    fill(32'h440, line2, 1, 1'b0);
    chk("cf_stall", stall_o, 1'b0);
    chk("cf_instr", instr_o, 32'h2000_0000);
    chk("cf_miss", miss_cnt_o, 32'd2);
    fill(32'h40, line1, 1, 1'b0);
    chk("cf2_instr", instr_o, 32'h1000_0000);
    chk("cf2_miss", miss_cnt_o, 32'd3);

    // Flush coincident with ack leaves the line invalid
    fill(32'h80, line3, 2, 1'b1);
    chk("fa_stall", stall_o, 1'b1);
    chk("fa_mreq0", mif.mem_req_o, 1'b0);
    @(negedge clk);
    #1;
    chk("fa_mreq1", mif.mem_req_o, 1'b1);
    chk("fa_maddr", mif.mem_addr_o, 32'h80);
    mif.mem_ack_i = 1'b1; mif.mem_data_i = line3;
    @(negedge clk);
    mif.mem_ack_i = 1'b0; addr_i = 32'h84;
    #1;
    chk("fa_instr", instr_o, 32'h3000_0001);
    chk("fa_miss", miss_cnt_o, 32'd5);

    // Miss with flush in IDLE does not start a fill
    @(negedge clk);
    addr_i = 32'hC0; flush_i = 1'b1;
    #1;
    chk("fi_stall", stall_o, 1'b1);
    @(negedge clk);
    req_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("fi_mreq", mif.mem_req_o, 1'b0);
    chk("fi_miss", miss_cnt_o, 32'd5);

    // Stray ack in IDLE with a hit pending
    fill(32'h40, line1, 1, 1'b0);
    chk("sa_pre", instr_o, 32'h1000_0000);
    @(negedge clk);
    addr_i = 32'h48; mif.mem_ack_i = 1'b1; mif.mem_data_i = {LW{1'b1}};
    #1;
    chk("sa_instr0", instr_o, 32'hDEAD_BEEF);
    @(negedge clk);
    mif.mem_ack_i = 1'b0;
    #1;
    chk("sa_instr1", instr_o, 32'hDEAD_BEEF);
    chk("sa_mreq", mif.mem_req_o, 1'b0);
    @(negedge clk);
    req_i = 1'b0;
    #1;
    chk("sa_hits", hit_cnt_o, 32'd16);
    chk("sa_miss", miss_cnt_o, 32'd6);

    // Reset in the middle of a fill, then a late ack
    @(negedge clk);
    req_i = 1'b1; addr_i = 32'h100;
    @(negedge clk);
    #1;
    chk("rf_mreq", mif.mem_req_o, 1'b1);
    rst_i = 1'b0; req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("rf_mreq0", mif.mem_req_o, 1'b0);
    chk("rf_maddr", mif.mem_addr_o, 32'h0);
    chk("rf_hits", hit_cnt_o, 32'h0);
    chk("rf_miss", miss_cnt_o, 32'h0);
    mif.mem_ack_i = 1'b1; mif.mem_data_i = line3;
    @(negedge clk);
    mif.mem_ack_i = 1'b0;
    #1;
    chk("rf_idle", mif.mem_req_o, 1'b0);
    @(negedge clk);
    req_i = 1'b1; addr_i = 32'h100;
    #1;
    chk("rf_inv100", stall_o, 1'b1);
    addr_i = 32'h48;
    #1;
    chk("rf_inv48", stall_o, 1'b1);
    chk("rf_nop", instr_o, 32'h0);
    req_i = 1'b0;
    @(negedge clk);
    #1;
    chk("rf_miss2", miss_cnt_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
